// File: rtl/epp_pkg.sv
// Shared types and default parameters for the EPP register bank.
package epp_pkg;

   localparam int unsigned EPP_DW          = 8;
   localparam int unsigned EPP_AW          = 8;
   localparam int unsigned DEF_NREGS       = 12;
   localparam int unsigned DEF_NCMDS       = 4;
   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_AUTOINC     = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

endpackage

// File: rtl/epp_sync.sv
// Multi-flop synchroniser for an asynchronous active-low strobe; resets to idle-high.
module epp_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] ff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff_q <= '1;
      else     ff_q <= {ff_q[N-2:0], d_i};
   end

   assign q_o = ff_q[N-1];

endmodule

// File: rtl/epp_regbank.sv
// EPP host port: address register, NREGS data registers, command strobes and status/error readback.
module epp_regbank
   import epp_pkg::*;
#(
   parameter int unsigned NREGS       = DEF_NREGS,
   parameter int unsigned NCMDS       = DEF_NCMDS,
   parameter int unsigned CMD_BASE    = NREGS,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned AUTOINC     = DEF_AUTOINC
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      EppAstb,
   input  logic                      EppDstb,
   input  logic                      EppWR,
   output logic                      EppWait,
   inout  wire  [EPP_DW-1:0]         EppDB,
   output logic [NREGS*EPP_DW-1:0]   reg_q,
   output logic [NCMDS-1:0]          cmd_pulse,
   output logic [EPP_DW-1:0]         cmd_data,
   input  logic [EPP_DW-1:0]         status,
   input  logic                      busy
);

   localparam int unsigned STAT_ADDR = CMD_BASE + NCMDS;

   state_e                    state_q, state_d;
   logic                      wait_q, wait_d;
   logic [EPP_AW-1:0]         addr_q, addr_d;
   logic [NREGS*EPP_DW-1:0]   regs_q, regs_d;
   logic [NCMDS-1:0]          cmd_pulse_q, cmd_pulse_d;
   logic [EPP_DW-1:0]         cmd_data_q, cmd_data_d;
   logic                      err_q, err_d;
   logic                      is_addr_q, is_addr_d;
   logic [EPP_DW-1:0]         rdata_q, rdata_d;
   logic                      err_set, err_clr;
   logic [EPP_DW-1:0]         rd_mux_c;
   logic [31:0]               addr_ext;
   logic                      astb_s, dstb_s;
   logic                      drive_c;

   epp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (
      .clk (clk), .rst (rst), .d_i (EppAstb), .q_o (astb_s)
   );

   epp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (
      .clk (clk), .rst (rst), .d_i (EppDstb), .q_o (dstb_s)
   );

   assign addr_ext = 32'(addr_q);

   // Data-read value for the current address; captured when the access starts.
   always_comb begin
      rd_mux_c = '0;
      for (int unsigned n = 0; n < NREGS; n++) begin
         if (addr_ext == n) rd_mux_c = regs_q[n*EPP_DW +: EPP_DW];
      end
      if (addr_ext == STAT_ADDR)     rd_mux_c = status;
      if (addr_ext == STAT_ADDR + 1) rd_mux_c = {6'b0, err_q, busy};
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      addr_d      = addr_q;
      regs_d      = regs_q;
      cmd_pulse_d = '0;
      cmd_data_d  = cmd_data_q;
      is_addr_d   = is_addr_q;
      rdata_d     = rdata_q;
      err_set     = 1'b0;
      err_clr     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!astb_s) begin
               is_addr_d = 1'b1;
               rdata_d   = addr_q;
               state_d   = ST_ACCESS;
            end else if (!dstb_s) begin
               is_addr_d = 1'b0;
               rdata_d   = rd_mux_c;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            wait_d  = 1'b1;
            state_d = ST_HOLD;
            if (is_addr_q) begin
               if (!EppWR) addr_d = EppDB;
            end else begin
               if (EppWR) begin
                  if (addr_ext == STAT_ADDR + 1) err_clr = 1'b1;
               end else begin
                  for (int unsigned n = 0; n < NREGS; n++) begin
                     if (addr_ext == n) regs_d[n*EPP_DW +: EPP_DW] = EppDB;
                  end
                  for (int unsigned k = 0; k < NCMDS; k++) begin
                     if (addr_ext == CMD_BASE + k) begin
                        if (busy) begin
                           err_set = 1'b1;
                        end else begin
                           cmd_pulse_d[k] = 1'b1;
                           cmd_data_d     = EppDB;
                        end
                     end
                  end
               end
               if (AUTOINC != 0) addr_d = addr_q + 8'd1;
            end
         end
         ST_HOLD: begin
            if (is_addr_q ? astb_s : dstb_s) begin
               wait_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            wait_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // A set in the same cycle as a status clear must not be lost.
      err_d = (err_q & ~err_clr) | err_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_q      <= 1'b0;
         addr_q      <= '0;
         regs_q      <= '0;
         cmd_pulse_q <= '0;
         cmd_data_q  <= '0;
         err_q       <= 1'b0;
         is_addr_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         regs_q      <= regs_d;
         cmd_pulse_q <= cmd_pulse_d;
         cmd_data_q  <= cmd_data_d;
         err_q       <= err_d;
         is_addr_q   <= is_addr_d;
         rdata_q     <= rdata_d;
      end
   end

   // Bus turns around only while the host holds the raw strobe of a read.
   assign drive_c = EppWR & ((state_q == ST_ACCESS) | (state_q == ST_HOLD)) &
                    (is_addr_q ? ~EppAstb : ~EppDstb);

   assign EppDB     = drive_c ? rdata_q : {EPP_DW{1'bz}};
   assign EppWait   = wait_q;
   assign reg_q     = regs_q;
   assign cmd_pulse = cmd_pulse_q;
   assign cmd_data  = cmd_data_q;

endmodule
